vslc_fetch_queue: RTL and testbench

//  Sits between the SPI EEPROM byte reader and the stack-machine executor.
//  - Parses the 4-byte program header (start/end address).
//  - Buffers instruction bytes in a small FIFO, each tagged with an end-of-scan flag.
//  - Hands instructions to the executor over a valid/ready handshake.
//  - Requests reader restarts at scan wrap, and on overflow replays from the first dropped byte.

---
 rtl/vslc_fetch_queue.sv | 196 +++++++++++++++++++
 tb/tb_vslc_fetch_queue.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vslc_fetch_queue.sv
// vslc_fetch_queue: sits between the SPI EEPROM byte reader and the stack-machine
// executor. Parses the 4-byte program header, buffers instruction bytes (tagged
// with an end-of-scan flag) in a small FIFO and requests reader restarts at scan
// wrap and after an overflow (replaying from the first dropped byte).
module vslc_fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 10
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           byte_valid,
   input  logic [7:0]                     byte_data,
   input  logic [15:0]                    byte_addr,
   output logic                           restart_req,
   output logic [15:0]                    fetch_addr,
   output logic                           prog_valid,
   output logic                           hdr_err,
   output logic                           overflow,
   output logic                           instr_valid,
   output logic [7:0]                     instr,
   output logic                           instr_last,
   input  logic                           instr_ready,
   output logic                           scan_done,
   output logic [$clog2(DEPTH+1)-1:0]     level
);

   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int HI_W  = ADDR_W - 8;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_SEEK = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // Assemble an ADDR_W header field from its high and low bytes, zero-extended to 16 bits.
   function automatic logic [15:0] hdr_field(input logic [HI_W-1:0] hi, input logic [7:0] lo);
      logic [15:0] f;
      f = 16'h0000;
      f[ADDR_W-1:0] = {hi, lo};
      return f;
   endfunction

   state_t            state_r;
   logic [HI_W-1:0]   hdr0_r;
   logic [7:0]        hdr1_r;
   logic [HI_W-1:0]   hdr2_r;
   logic [15:0]       start_r;
   logic [15:0]       end_r;

   logic [8:0]        mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [LVL_W-1:0]  level_r;

   logic              pop_s;
   logic              take_s;
   logic              push_s;
   logic              drop_s;
   logic              last_s;
   logic              hdr_done_s;
   logic [15:0]       hdr_start_s;
   logic [15:0]       hdr_end_s;
   logic              hdr_good_s;

   assign instr_valid = (level_r != {LVL_W{1'b0}});
   assign instr       = mem_r[rd_ptr_r][7:0];
   assign instr_last  = mem_r[rd_ptr_r][8];
   assign level       = level_r;

   // Decode this cycle's byte: whether it is taken, pushed or dropped, and header evaluation.
   always_comb begin
      pop_s  = instr_valid && instr_ready;
      take_s = 1'b0;
      case (state_r)
         ST_HDR:  take_s = 1'b0;
         ST_SEEK: take_s = byte_valid && (byte_addr == fetch_addr);
         ST_RUN:  take_s = byte_valid;
         default: take_s = 1'b0;
      endcase
      // A full FIFO still accepts the byte when the head leaves in the same cycle.
      if (level_r != FULL_LVL) begin
         push_s = take_s;
         drop_s = 1'b0;
      end else begin
         push_s = take_s && pop_s;
         drop_s = take_s && !pop_s;
      end
      last_s      = (byte_addr == end_r);
      hdr_done_s  = (state_r == ST_HDR) && byte_valid && (byte_addr == 16'd3);
      hdr_start_s = hdr_field(hdr0_r, hdr1_r);
      hdr_end_s   = hdr_field(hdr2_r, byte_data);
      hdr_good_s  = (hdr_end_s != 16'h0000) && (hdr_start_s <= hdr_end_s);
   end

   // FIFO storage, pointers and exact occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 9'h000;
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= {last_s, byte_data};
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LVL_W'(1);
            2'b01:   level_r <= level_r - LVL_W'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   // Header parse / seek / run sequencing with registered status and restart outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_HDR;
         hdr0_r      <= {HI_W{1'b0}};
         hdr1_r      <= 8'h00;
         hdr2_r      <= {HI_W{1'b0}};
         start_r     <= 16'h0000;
         end_r       <= 16'h0000;
         restart_req <= 1'b0;
         fetch_addr  <= 16'h0000;
         prog_valid  <= 1'b0;
         hdr_err     <= 1'b0;
         overflow    <= 1'b0;
         scan_done   <= 1'b0;
      end else begin
         restart_req <= 1'b0;
         scan_done   <= pop_s && instr_last;
         case (state_r)
            ST_HDR: begin
               if (byte_valid && (byte_addr == 16'd0)) begin
                  hdr0_r <= byte_data[HI_W-1:0];
               end else if (byte_valid && (byte_addr == 16'd1)) begin
                  hdr1_r <= byte_data;
               end else if (byte_valid && (byte_addr == 16'd2)) begin
                  hdr2_r <= byte_data[HI_W-1:0];
               end else begin
                  hdr0_r <= hdr0_r;
               end
               if (hdr_done_s && hdr_good_s) begin
                  start_r     <= hdr_start_s;
                  end_r       <= hdr_end_s;
                  prog_valid  <= 1'b1;
                  hdr_err     <= 1'b0;
                  fetch_addr  <= hdr_start_s;
                  restart_req <= 1'b1;
                  state_r     <= ST_SEEK;
               end else if (hdr_done_s) begin
                  // Rejected header: rewind the reader to address 0 and parse again.
                  prog_valid  <= 1'b0;
                  hdr_err     <= 1'b1;
                  fetch_addr  <= 16'h0000;
                  restart_req <= 1'b1;
                  state_r     <= ST_HDR;
               end else begin
                  state_r <= ST_HDR;
               end
            end
            ST_SEEK, ST_RUN: begin
               if (drop_s) begin
                  // Replay from the first byte that did not fit.
                  overflow    <= 1'b1;
                  fetch_addr  <= byte_addr;
                  restart_req <= 1'b1;
                  state_r     <= ST_SEEK;
               end else if (push_s && last_s) begin
                  // Scan complete: wrap the reader back to the program start.
                  fetch_addr  <= start_r;
                  restart_req <= 1'b1;
                  state_r     <= ST_SEEK;
               end else if (push_s) begin
                  state_r <= ST_RUN;
               end else begin
                  state_r <= state_r;
               end
            end
            default: begin
               state_r <= ST_HDR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vslc_fetch_queue.sv
// Self-checking bench for vslc_fetch_queue: directed scenarios plus a randomized
// reader/executor run, all checked against a queue-based behavioural model.
module tb_vslc_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic [15:0] byte_addr = 16'h0000;
   logic        instr_ready = 1'b0;
   logic        restart_req;
   logic [15:0] fetch_addr;
   logic        prog_valid;
   logic        hdr_err;
   logic        overflow;
   logic        instr_valid;
   logic [7:0]  instr;
   logic        instr_last;
   logic        scan_done;
   logic [2:0]  level;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vslc_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_addr(byte_addr), .restart_req(restart_req), .fetch_addr(fetch_addr),
      .prog_valid(prog_valid), .hdr_err(hdr_err), .overflow(overflow),
      .instr_valid(instr_valid), .instr(instr), .instr_last(instr_last),
      .instr_ready(instr_ready), .scan_done(scan_done), .level(level)
   );

   // Observed outputs; instruction fields only matter while instr_valid is high.
   wire [33:0] obs_vec = {restart_req, fetch_addr, prog_valid, hdr_err, overflow, instr_valid,
                          (instr_valid ? {instr_last, instr} : 9'h000), scan_done, level};

   // ---------------- behavioural model ----------------
   int          m_phase;          // 0 = reading header, 1 = looking for fetch_addr, 2 = streaming
   logic [7:0]  m_hdr [4];
   logic [15:0] m_start, m_end, m_fetch;
   bit          m_prog, m_err, m_ovf, m_restart, m_scan;
   logic [8:0]  q [$];

   task automatic model_reset();
      m_phase = 0; m_start = 16'h0; m_end = 16'h0; m_fetch = 16'h0;
      m_prog = 0; m_err = 0; m_ovf = 0; m_restart = 0; m_scan = 0;
      for (int i = 0; i < 4; i++) m_hdr[i] = 8'h00;
      q.delete();
   endtask

   task automatic model_step(input bit bv, input logic [7:0] bd, input logic [15:0] ba, input bit rdy);
      bit pop, popped_last, fits, wanted;
      logic [15:0] s, e;
      pop = (q.size() > 0) && rdy;
      popped_last = pop && q[0][8];
      fits = (q.size() < DEPTH) || pop;
      wanted = bv && ((m_phase == 2) || (m_phase == 1 && ba == m_fetch));
      m_restart = 0;
      if (pop) void'(q.pop_front());
      if (m_phase == 0) begin
         if (bv && ba < 16'd3) m_hdr[ba[1:0]] = bd;
         if (bv && ba == 16'd3) begin
            s = {6'b0, m_hdr[0][1:0], m_hdr[1]};
            e = {6'b0, m_hdr[2][1:0], bd};
            m_restart = 1;
            if (e != 16'h0 && s <= e) begin
               m_start = s; m_end = e; m_fetch = s; m_prog = 1; m_err = 0; m_phase = 1;
            end else begin
               m_fetch = 16'h0; m_prog = 0; m_err = 1;
            end
         end
      end else if (wanted) begin
         if (!fits) begin
            m_ovf = 1; m_fetch = ba; m_restart = 1; m_phase = 1;
         end else begin
            q.push_back({ba == m_end, bd});
            if (ba == m_end) begin
               m_fetch = m_start; m_restart = 1; m_phase = 1;
            end else begin
               m_phase = 2;
            end
         end
      end
      m_scan = popped_last;
   endtask

   function automatic logic [33:0] exp_vec();
      logic [8:0] head;
      head = (q.size() > 0) ? q[0] : 9'h000;
      return {m_restart, m_fetch, m_prog, m_err, m_ovf, 1'(q.size() != 0), head, m_scan, 3'(q.size())};
   endfunction

   function automatic logic [7:0] dat(input logic [15:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick(input bit bv, input logic [7:0] bd, input logic [15:0] ba, input bit rdy);
      byte_valid = bv; byte_data = bd; byte_addr = ba; instr_ready = rdy;
      model_step(bv, bd, ba, rdy);
      @(posedge clk);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; byte_valid = 1'b0; instr_ready = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic load_header(input logic [7:0] b0, b1, b2, b3);
      tick(1, b0, 16'd0, 0);
      tick(1, b1, 16'd1, 0);
      tick(1, b2, 16'd2, 0);
      tick(1, b3, 16'd3, 0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (obs_vec !== 34'h0) begin
         failures++; $display("FAIL reset outputs: got %h want %h", obs_vec, 34'h0);
      end
   endtask

   task automatic test_header();
      do_reset();
      load_header(8'h00, 8'h10, 8'h00, 8'h13);
      checks++;
      if (prog_valid !== 1'b1 || restart_req !== 1'b1 || fetch_addr !== 16'h0010 || hdr_err !== 1'b0) begin
         failures++; $display("FAIL header_accept: got pv=%b rr=%b fa=%h he=%b want 1 1 0010 0",
                              prog_valid, restart_req, fetch_addr, hdr_err);
      end
      for (int a = 4; a <= 15; a++) begin
         tick(1, dat(16'(a)), 16'(a), 1);
         checks++;
         if (level !== 3'd0 || restart_req !== 1'b0 || obs_vec !== exp_vec()) begin
            failures++; $display("FAIL header_discard a=%0d: got %h want %h", a, obs_vec, exp_vec());
         end
      end
   endtask

   task automatic test_stream();
      int scans = 0;
      bit saw_last = 0;
      for (int a = 16'h10; a <= 16'h13; a++) begin
         tick(1, dat(16'(a)), 16'(a), 1);
         checks++;
         if (obs_vec !== exp_vec()) begin
            failures++; $display("FAIL stream a=%h: got %h want %h", a, obs_vec, exp_vec());
         end
         if (instr_valid && instr_last && instr === dat(16'h13)) saw_last = 1;
         if (scan_done) scans++;
      end
      checks++;
      if (restart_req !== 1'b1 || fetch_addr !== 16'h0010) begin
         failures++; $display("FAIL stream_wrap: got rr=%b fa=%h want 1 0010", restart_req, fetch_addr);
      end
      for (int i = 0; i < 3; i++) begin
         tick(0, 8'h00, 16'h0, 1);
         if (scan_done) scans++;
         checks++;
         if (obs_vec !== exp_vec()) begin
            failures++; $display("FAIL stream_drain i=%0d: got %h want %h", i, obs_vec, exp_vec());
         end
      end
      checks++;
      if (scans != 1 || !saw_last || level !== 3'd0) begin
         failures++; $display("FAIL stream_scan: got scans=%0d last_seen=%0d level=%0d want 1 1 0",
                              scans, saw_last, level);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      load_header(8'h00, 8'h10, 8'h00, 8'h1F);
      for (int a = 16'h10; a <= 16'h14; a++) tick(1, dat(16'(a)), 16'(a), 0);
      checks++;
      if (overflow !== 1'b1 || fetch_addr !== 16'h0014 || restart_req !== 1'b1 || level !== 3'd4) begin
         failures++; $display("FAIL overflow_drop: got ov=%b fa=%h rr=%b lvl=%0d want 1 0014 1 4",
                              overflow, fetch_addr, restart_req, level);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (instr_valid !== 1'b1 || instr !== dat(16'(16'h10 + k))) begin
            failures++; $display("FAIL overflow_order k=%0d: got %h want %h", k, instr, dat(16'(16'h10 + k)));
         end
         tick(0, 8'h00, 16'h0, 1);
      end
      // Stale byte before the replay point is discarded, then 0x14 resumes the stream.
      tick(1, dat(16'h13), 16'h13, 1);
      tick(1, dat(16'h14), 16'h14, 1);
      checks++;
      if (instr_valid !== 1'b1 || instr !== dat(16'h14) || level !== 3'd1) begin
         failures++; $display("FAIL overflow_replay: got v=%b instr=%h lvl=%0d want 1 %h 1",
                              instr_valid, instr, level, dat(16'h14));
      end
      tick(1, dat(16'h15), 16'h15, 1);
      checks++;
      if (obs_vec !== exp_vec() || instr !== dat(16'h15)) begin
         failures++; $display("FAIL overflow_next: got %h want %h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_full_pop();
      do_reset();
      load_header(8'h00, 8'h10, 8'h00, 8'h1F);
      for (int a = 16'h10; a <= 16'h13; a++) tick(1, dat(16'(a)), 16'(a), 0);
      tick(1, dat(16'h14), 16'h14, 1);
      checks++;
      if (level !== 3'd4 || overflow !== 1'b0 || restart_req !== 1'b0 || instr !== dat(16'h11)) begin
         failures++; $display("FAIL full_pop: got lvl=%0d ov=%b rr=%b instr=%h want 4 0 0 %h",
                              level, overflow, restart_req, instr, dat(16'h11));
      end
      for (int i = 0; i < 5; i++) begin
         tick(0, 8'h00, 16'h0, 1);
         checks++;
         if (obs_vec !== exp_vec()) begin
            failures++; $display("FAIL full_pop_drain i=%0d: got %h want %h", i, obs_vec, exp_vec());
         end
      end
   endtask

   task automatic test_bad_header();
      do_reset();
      load_header(8'h00, 8'h00, 8'h00, 8'h00);
      checks++;
      if (hdr_err !== 1'b1 || prog_valid !== 1'b0 || restart_req !== 1'b1 || fetch_addr !== 16'h0000) begin
         failures++; $display("FAIL bad_hdr_end0: got he=%b pv=%b rr=%b fa=%h want 1 0 1 0000",
                              hdr_err, prog_valid, restart_req, fetch_addr);
      end
      load_header(8'h00, 8'h20, 8'h00, 8'h10);
      checks++;
      if (hdr_err !== 1'b1 || prog_valid !== 1'b0 || restart_req !== 1'b1 || fetch_addr !== 16'h0000) begin
         failures++; $display("FAIL bad_hdr_order: got he=%b pv=%b rr=%b fa=%h want 1 0 1 0000",
                              hdr_err, prog_valid, restart_req, fetch_addr);
      end
      tick(1, dat(16'h20), 16'h20, 0);
      checks++;
      if (level !== 3'd0 || obs_vec !== exp_vec()) begin
         failures++; $display("FAIL bad_hdr_stay: got %h want %h", obs_vec, exp_vec());
      end
      load_header(8'h00, 8'h08, 8'h00, 8'h0C);
      checks++;
      if (hdr_err !== 1'b0 || prog_valid !== 1'b1 || fetch_addr !== 16'h0008) begin
         failures++; $display("FAIL bad_hdr_retry: got he=%b pv=%b fa=%h want 0 1 0008",
                              hdr_err, prog_valid, fetch_addr);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      load_header(8'h00, 8'h10, 8'h00, 8'h1F);
      for (int a = 16'h10; a <= 16'h12; a++) tick(1, dat(16'(a)), 16'(a), 0);
      checks++;
      if (level !== 3'd3) begin
         failures++; $display("FAIL async_pre: got lvl=%0d want 3", level);
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (instr_valid !== 1'b0 || level !== 3'd0 || prog_valid !== 1'b0) begin
         failures++; $display("FAIL async_clear: got v=%b lvl=%0d pv=%b want 0 0 0", instr_valid, level, prog_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      load_header(8'h00, 8'h10, 8'h00, 8'h13);
      checks++;
      if (prog_valid !== 1'b1 || fetch_addr !== 16'h0010 || obs_vec !== exp_vec()) begin
         failures++; $display("FAIL async_reparse: got %h want %h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      logic [7:0] image [64];
      int rd;
      int st, en;
      bit bv, rdy;
      for (int round = 0; round < 4; round++) begin
         do_reset();
         st = $urandom_range(4, 40);
         en = (round == 0) ? 0 : st + $urandom_range(0, 10);
         for (int i = 4; i < 64; i++) image[i] = 8'($urandom_range(0, 255));
         image[0] = 8'(st >> 8); image[1] = 8'(st);
         image[2] = 8'(en >> 8); image[3] = 8'(en);
         rd = 0;
         for (int c = 0; c < 400; c++) begin
            bv  = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 2) != 0);
            tick(bv, image[rd], 16'(rd), rdy);
            checks++;
            if (obs_vec !== exp_vec()) begin
               failures++; $display("FAIL random r=%0d c=%0d: got %h want %h", round, c, obs_vec, exp_vec());
            end
            if (bv) rd = (rd + 1) % 64;
            if (m_restart) rd = int'(m_fetch);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_header();
      test_stream();
      test_overflow();
      test_full_pop();
      test_bad_header();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
